// File: rtl/vector_argmax.sv
// Streaming argmax: accepts K signed words per vector over valid/ready and
// reports the index and value of the largest word, with ties going to the lowest index.
module vector_argmax #(
    parameter int K  = 4,
    parameter int T  = 8,
    parameter int IW = (K > 1) ? $clog2(K) : 1,
    parameter int CW = $clog2(K + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [T-1:0]  data_in,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [IW-1:0] idx_out,
    output logic [T-1:0]  max_out
);

    typedef enum logic {ACC, OUT} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [T-1:0]  best;
    logic [IW-1:0] bidx;
    logic          accept;
    logic          last_word;
    logic          take_new;
    logic [T-1:0]  cand_best;
    logic [IW-1:0] cand_idx;

    assign s_ready   = (state == ACC) && reset;
    assign accept    = s_valid && s_ready;
    assign last_word = (cnt == CW'(K - 1));

    // The first word of a vector always seeds the running best; after that,
    // only a strictly larger word replaces it, so earlier indices win ties.
    assign take_new  = (cnt == '0) || ($signed(data_in) > $signed(best));
    assign cand_best = take_new ? data_in : best;
    assign cand_idx  = take_new ? IW'(cnt) : bidx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACC: if (accept && last_word) state_next = OUT;
            OUT: if (m_ready)             state_next = ACC;
            default:                      state_next = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            best    <= '0;
            bidx    <= '0;
            m_valid <= 1'b0;
            idx_out <= '0;
            max_out <= '0;
        end else if (accept) begin
            best <= cand_best;
            bidx <= cand_idx;
            if (last_word) begin
                cnt     <= '0;
                m_valid <= 1'b1;
                idx_out <= cand_idx;
                max_out <= cand_best;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vector_argmax.sv
// Randomized and directed bench for vector_argmax, comparing K=4 and K=1 builds
// against a plain argmax reference model.
module tb_vector_argmax;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] data_in;
    logic       m_valid;
    logic       m_ready;
    logic [1:0] idx_out;
    logic [7:0] max_out;

    logic       k1_s_valid;
    logic       k1_s_ready;
    logic [7:0] k1_data_in;
    logic       k1_m_valid;
    logic       k1_m_ready;
    logic [0:0] k1_idx_out;
    logic [7:0] k1_max_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    vector_argmax #(.K(4), .T(8)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
        .m_valid(m_valid), .m_ready(m_ready),
        .idx_out(idx_out), .max_out(max_out)
    );

    vector_argmax #(.K(1), .T(8)) dut_k1 (
        .clk(clk), .reset(reset),
        .s_valid(k1_s_valid), .s_ready(k1_s_ready), .data_in(k1_data_in),
        .m_valid(k1_m_valid), .m_ready(k1_m_ready),
        .idx_out(k1_idx_out), .max_out(k1_max_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: find the maximum value, then the first position holding it.
    function automatic void ref_argmax(input int v[4], output int ridx, output int rmax);
        rmax = -129;
        for (int i = 0; i < 4; i++) if (v[i] > rmax) rmax = v[i];
        ridx = -1;
        for (int i = 0; i < 4; i++) if (ridx < 0 && v[i] == rmax) ridx = i;
    endfunction

    task automatic push(input int w);
        int n;
        s_valid = 1'b1;
        data_in = 8'(w);
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: s_ready got %b required 1", s_ready);
        end else begin
            @(posedge clk);
        end
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int n;
        n = 0;
        while (!m_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_timeout: m_valid got %b required 1", name, m_valid);
        end
    endtask

    task automatic run_vector(input int v[4], input bit gaps, input int hold, input string name);
        int ridx;
        int rmax;
        ref_argmax(v, ridx, rmax);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            push(v[i]);
        end
        wait_result(name);
        checks++;
        if (idx_out !== 2'(ridx)) begin
            errors++;
            $display("[TB] FAIL %s_idx: got %0d required %0d", name, idx_out, ridx);
        end
        checks++;
        if (max_out !== 8'(rmax)) begin
            errors++;
            $display("[TB] FAIL %s_max: got %0d required %0d", name, $signed(max_out), rmax);
        end
        s_valid = 1'b1;
        data_in = 8'h7f;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            checks++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || idx_out !== 2'(ridx) || max_out !== 8'(rmax)) begin
                errors++;
                $display("[TB] FAIL %s_hold: got v=%b r=%b idx=%0d max=%0d required v=1 r=0 idx=%0d max=%0d",
                         name, m_valid, s_ready, idx_out, $signed(max_out), ridx, rmax);
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || idx_out !== 2'(ridx) || max_out !== 8'(rmax)) begin
            errors++;
            $display("[TB] FAIL %s_release: got v=%b r=%b idx=%0d max=%0d required v=0 r=1 idx=%0d max=%0d",
                     name, m_valid, s_ready, idx_out, $signed(max_out), ridx, rmax);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || k1_s_ready !== 1'b0 || k1_m_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshake: got r=%b v=%b k1r=%b k1v=%b required all 0",
                     s_ready, m_valid, k1_s_ready, k1_m_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (idx_out !== 2'd0 || max_out !== 8'd0 || s_ready !== 1'b1 || k1_max_out !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got idx=%0d max=%0d r=%b k1max=%0d required 0 0 1 0",
                     idx_out, max_out, s_ready, k1_max_out);
        end
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b1;
        push(3);
        push(9);
        push(2);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_early: m_valid got %b required 0", m_valid);
        end
        push(7);
        checks++;
        if (m_valid !== 1'b1 || idx_out !== 2'd1 || max_out !== 8'd9 || s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_result: got v=%b idx=%0d max=%0d r=%b required 1 1 9 0",
                     m_valid, idx_out, $signed(max_out), s_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || idx_out !== 2'd1 || max_out !== 8'd9) begin
            errors++;
            $display("[TB] FAIL b2b_after: got v=%b r=%b idx=%0d max=%0d required 0 1 1 9",
                     m_valid, s_ready, idx_out, $signed(max_out));
        end
        m_ready = 1'b0;
    endtask

    task automatic test_ties();
        int v[4];
        v = '{5, 5, 1, 5};
        run_vector(v, 1'b0, 0, "ties");
        v = '{-128, -3, -7, -128};
        run_vector(v, 1'b0, 0, "negative");
    endtask

    task automatic test_backpressure();
        int v[4];
        v = '{-5, 20, 20, -1};
        run_vector(v, 1'b0, 6, "backpressure");
        v = '{0, 0, 0, 4};
        run_vector(v, 1'b0, 0, "after_bp");
    endtask

    task automatic test_gapped();
        bit pattern[7];
        int words[4];
        int w;
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        words = '{3, 9, 2, 7};
        w = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_valid = pattern[i];
            data_in = pattern[i] ? 8'(words[w]) : 8'h7f;
            if (pattern[i]) w++;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || idx_out !== 2'd1 || max_out !== 8'd9) begin
            errors++;
            $display("[TB] FAIL gapped: got v=%b idx=%0d max=%0d required 1 1 9",
                     m_valid, idx_out, $signed(max_out));
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        int v[4];
        push(50);
        push(60);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0 || idx_out !== 2'd0 || max_out !== 8'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got v=%b r=%b idx=%0d max=%0d required all 0",
                     m_valid, s_ready, idx_out, max_out);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        v = '{1, 2, 3, 0};
        run_vector(v, 1'b0, 0, "post_reset");
    endtask

    task automatic test_random();
        int v[4];
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0: v[i] = int'($urandom_range(0, 255)) - 128;
                    1: v[i] = -128;
                    2: v[i] = 127;
                    default: v[i] = int'($urandom_range(0, 3));
                endcase
            end
            run_vector(v, 1'b1, int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_k1();
        int words[3];
        int prev;
        int n;
        words = '{7, -1, 4};
        prev = 0;
        k1_m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            k1_s_valid = 1'b1;
            k1_data_in = 8'(words[i]);
            n = 0;
            while (!k1_s_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1;
            checks++;
            if (k1_m_valid !== 1'b1 || k1_idx_out !== 1'b0 || k1_max_out !== 8'(words[i])) begin
                errors++;
                $display("[TB] FAIL k1_result: got v=%b idx=%0d max=%0d required 1 0 %0d",
                         k1_m_valid, k1_idx_out, $signed(k1_max_out), words[i]);
            end
            if (i > 0) begin
                checks++;
                if (cyc - prev !== 2) begin
                    errors++;
                    $display("[TB] FAIL k1_spacing: got %0d cycles required 2", cyc - prev);
                end
            end
            prev = cyc;
        end
        k1_s_valid = 1'b0;
        @(posedge clk);
        #1;
        k1_m_ready = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        s_valid    = 1'b0;
        data_in    = '0;
        m_ready    = 1'b0;
        k1_s_valid = 1'b0;
        k1_data_in = '0;
        k1_m_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_ties();
        test_backpressure();
        test_gapped();
        test_async_reset();
        test_random();
        test_k1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
